seg7_mux_decoder: RTL and testbench

//   Receive side of the dual seven-segment display bus {sel, seg[6:0]}.
//   sel=1 carries the tens digit and sel=0 carries the ones digit, time-multiplexed.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_mux_decoder_if.sv | 33 +++
 rtl/seg7_pattern_decode.sv | 33 +++
 rtl/seg7_mux_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_seg7_mux_decoder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display bus receiver.
// Contents:
//   SEG_0..SEG_9, SEG_BLANK : active-high segment patterns (bit0=a ... bit6=g),
//                             identical to the ones used by the display encoder
//   DIG_BLANK               : digit code reported for a dark (blank) display
//   seg7_dec_state_t        : receiver phase-tracking FSM states
//   seg7_bcd_to_bin         : {tens,ones} BCD pair to binary, 7'h7F when blank
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIG_BLANK = 4'hF;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} seg7_dec_state_t;

  // tens*10 is built from two shifts; inputs are always 0-9 or DIG_BLANK.
  function automatic logic [6:0] seg7_bcd_to_bin(input logic [3:0] tens,
                                                 input logic [3:0] ones);
    logic [6:0] t7;
    logic [6:0] o7;
    if (tens == DIG_BLANK || ones == DIG_BLANK) begin
      return 7'h7F;
    end
    t7 = {3'b000, tens};
    o7 = {3'b000, ones};
    return (t7 << 3) + (t7 << 1) + o7;
  endfunction

endpackage

// File: rtl/seg7_mux_decoder_if.sv
// Display-bus receiver interface.
// Signals:
//   disp_in     [7]=sel (1=tens, 0=ones), [6:0]=segment pattern
//   err_clr     synchronous clear of err_seg
//   tens_out    last frame tens digit (4'hF = blank)
//   ones_out    last frame ones digit (4'hF = blank)
//   frame_valid one-cycle pulse when tens_out/ones_out update
//   err_seg     sticky illegal-pattern flag
//   link_live   sel is still toggling
//   value_out   binary value of the last frame (optional feature, else 0)
// Modports: master = bus/stimulus side, slave = decoder side.
interface seg7_mux_decoder_if;

  logic [7:0] disp_in;
  logic       err_clr;
  logic [3:0] tens_out;
  logic [3:0] ones_out;
  logic       frame_valid;
  logic       err_seg;
  logic       link_live;
  logic [6:0] value_out;

  modport master (
    output disp_in, err_clr,
    input  tens_out, ones_out, frame_valid, err_seg, link_live, value_out
  );

  modport slave (
    input  disp_in, err_clr,
    output tens_out, ones_out, frame_valid, err_seg, link_live, value_out
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decoder.
// Ports:
//   seg   in  7  segment pattern, bit0=a ... bit6=g, active high
//   digit out 4  0-9, or DIG_BLANK for an all-dark pattern
//   legal out 1  pattern is one of 0-9 or blank
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = DIG_BLANK;
    legal = 1'b1;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = DIG_BLANK;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_mux_decoder.sv
// Receive side of the time-multiplexed dual seven-segment display bus.
// Debounces each sel phase, decodes the pattern, reassembles {tens,ones}
// frames, flags illegal patterns and watches for a stalled bus.
// Ports:
//   clk    in  clock
//   reset  in  asynchronous, active-high
//   bus    seg7_mux_decoder_if.slave (disp_in, err_clr in; frame/status out)
// Parameters:
//   STABLE_CYCLES  identical consecutive samples needed to capture a phase (>=1)
//   TIMEOUT_CYCLES cycles without a sel toggle before link_live drops (>=4)
// Build option:
//   SEG7_DEC_BINARY_EN  when defined, value_out carries tens*10+ones
//                       (7'h7F if either digit is blank); otherwise 7'h00.
module seg7_mux_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               reset,
  seg7_mux_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STAB_TARGET = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] STAB_ONE    = CW'(1);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_ONE      = TW'(1);

  // Input sampling. The valid bits keep the reset value of the sample
  // registers from looking like a sel toggle right after reset.
  logic [7:0] sample_reg;
  logic [7:0] prev_reg;
  logic       sample_vld_reg;
  logic       prev_vld_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_reg     <= 8'h00;
      prev_reg       <= 8'h00;
      sample_vld_reg <= 1'b0;
      prev_vld_reg   <= 1'b0;
    end else begin
      sample_reg     <= bus.disp_in;
      prev_reg       <= sample_reg;
      sample_vld_reg <= 1'b1;
      prev_vld_reg   <= sample_vld_reg;
    end
  end

  logic sel_chg;
  logic same;
  assign sel_chg = prev_vld_reg && (sample_reg[7] != prev_reg[7]);
  assign same    = prev_vld_reg && (sample_reg == prev_reg);

  logic [3:0] dec_digit;
  logic       dec_legal;

  seg7_pattern_decode u_decode (
    .seg   (sample_reg[6:0]),
    .digit (dec_digit),
    .legal (dec_legal)
  );

  // Phase-tracking FSM
  seg7_dec_state_t state_reg, state_next;
  logic [CW-1:0]   stab_cnt_reg, stab_cnt_next;
  logic [TW-1:0]   to_cnt_reg, to_cnt_next;
  logic [CW-1:0]   stab_inc;
  logic            to_sat;
  logic            capture;     // current phase is stable long enough
  logic            phase_drop;  // phase ended without a capture

  assign stab_inc = stab_cnt_reg + STAB_ONE;
  assign to_sat   = (to_cnt_reg == TO_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      stab_cnt_reg <= '0;
      to_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      stab_cnt_reg <= stab_cnt_next;
      to_cnt_reg   <= to_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    stab_cnt_next = stab_cnt_reg;
    capture       = 1'b0;
    phase_drop    = 1'b0;
    to_cnt_next   = to_sat ? to_cnt_reg : (to_cnt_reg + TO_ONE);
    if (sel_chg) begin
      to_cnt_next = '0;
    end

    case (state_reg)
      IDLE: begin
        if (sel_chg) begin
          state_next    = SETTLE;
          stab_cnt_next = STAB_ONE;
        end
      end
      SETTLE: begin
        if (sel_chg) begin
          // Phase ended before it settled: the frame it belongs to is lost.
          stab_cnt_next = STAB_ONE;
          phase_drop    = 1'b1;
        end else if (to_sat) begin
          state_next = IDLE;
          phase_drop = 1'b1;
        end else if (same) begin
          if (stab_inc >= STAB_TARGET) begin
            capture    = 1'b1;
            state_next = HELD;
          end else begin
            stab_cnt_next = stab_inc;
          end
        end else begin
          // Segment change inside the phase: restart debounce.
          stab_cnt_next = STAB_ONE;
        end
      end
      HELD: begin
        if (sel_chg) begin
          state_next    = SETTLE;
          stab_cnt_next = STAB_ONE;
        end else if (to_sat) begin
          // Bus stalled: forget any armed tens so re-lock needs a full pair.
          state_next = IDLE;
          phase_drop = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.link_live = (state_reg != IDLE) && !to_sat;

  // Frame assembly
  logic       t_ok_reg;
  logic       t_valid_reg;
  logic [3:0] t_hold_reg;
  logic [3:0] tens_reg;
  logic [3:0] ones_reg;
  logic       frame_valid_reg;
  logic       err_seg_reg;
  logic       frame_load;

  assign frame_load = capture && !sample_reg[7] && t_ok_reg && t_valid_reg && dec_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_ok_reg        <= 1'b0;
      t_valid_reg     <= 1'b0;
      t_hold_reg      <= DIG_BLANK;
      tens_reg        <= DIG_BLANK;
      ones_reg        <= DIG_BLANK;
      frame_valid_reg <= 1'b0;
      err_seg_reg     <= 1'b0;
    end else begin
      frame_valid_reg <= frame_load;

      if (capture && !dec_legal) begin
        err_seg_reg <= 1'b1;
      end else if (bus.err_clr) begin
        err_seg_reg <= 1'b0;
      end

      if (phase_drop) begin
        t_ok_reg <= 1'b0;
      end

      if (capture) begin
        if (sample_reg[7]) begin
          t_ok_reg    <= 1'b1;
          t_valid_reg <= dec_legal;
          t_hold_reg  <= dec_digit;
        end else begin
          t_ok_reg <= 1'b0;
        end
      end

      if (frame_load) begin
        tens_reg <= t_hold_reg;
        ones_reg <= dec_digit;
      end
    end
  end

  assign bus.tens_out    = tens_reg;
  assign bus.ones_out    = ones_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.err_seg     = err_seg_reg;

`ifdef SEG7_DEC_BINARY_EN
  logic [6:0] value_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_reg <= 7'h00;
    end else if (frame_load) begin
      value_reg <= seg7_bcd_to_bin(t_hold_reg, dec_digit);
    end
  end

  assign bus.value_out = value_reg;
`else
  assign bus.value_out = 7'h00;
`endif

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Directed testbench for seg7_mux_decoder (STABLE_CYCLES=2, TIMEOUT_CYCLES=64).
// Each step() holds one disp_in value for one clock; outputs are sampled at
// the falling edge in the middle of that step.
module tb_seg7_mux_decoder;

  // Hand-written segment patterns (bit0=a ... bit6=g)
  localparam logic [6:0] P1  = 7'h06;
  localparam logic [6:0] P2  = 7'h5B;
  localparam logic [6:0] P3  = 7'h4F;
  localparam logic [6:0] P4  = 7'h66;
  localparam logic [6:0] P5  = 7'h6D;
  localparam logic [6:0] P6  = 7'h7D;
  localparam logic [6:0] P7  = 7'h07;
  localparam logic [6:0] P8  = 7'h7F;
  localparam logic [6:0] P9  = 7'h6F;
  localparam logic [6:0] PBL = 7'h00;
  localparam logic [6:0] PBAD = 7'h55;

`ifdef SEG7_DEC_BINARY_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   passed;
  int   total;
  int   fv_cnt;
  logic fv_s;
  logic ll_s;

  seg7_mux_decoder_if bus_if ();

  seg7_mux_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every frame_valid pulse
  always @(negedge clk) begin
    if (bus_if.frame_valid === 1'b1) fv_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  function automatic logic [7:0] tn(input logic [6:0] s);
    return {1'b1, s};
  endfunction

  function automatic logic [7:0] on(input logic [6:0] s);
    return {1'b0, s};
  endfunction

  task automatic step(input logic [7:0] v);
    bus_if.disp_in = v;
    @(negedge clk);
    fv_s = bus_if.frame_valid;
    ll_s = bus_if.link_live;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_if.disp_in = 8'h00;
    bus_if.err_clr = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Steps 0..n-1 of a clean alternating tens/ones stream, 2 cycles per phase
  task automatic pairs(input logic [6:0] t, input logic [6:0] o, input int n);
    for (int k = 0; k < n; k++) begin
      step(((k % 4) < 2) ? tn(t) : on(o));
    end
  endtask

  task automatic test_reset();
    bus_if.disp_in = tn(P8);
    bus_if.err_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus_if.tens_out !== 4'hF) $display("FAIL reset_tens: got %h want f", bus_if.tens_out); else passed++;
    total++; if (bus_if.ones_out !== 4'hF) $display("FAIL reset_ones: got %h want f", bus_if.ones_out); else passed++;
    total++; if (bus_if.frame_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", bus_if.frame_valid); else passed++;
    total++; if (bus_if.err_seg !== 1'b0) $display("FAIL reset_err: got %b want 0", bus_if.err_seg); else passed++;
    total++; if (bus_if.link_live !== 1'b0) $display("FAIL reset_live: got %b want 0", bus_if.link_live); else passed++;
    total++; if (bus_if.value_out !== 7'h00) $display("FAIL reset_value: got %h want 00", bus_if.value_out); else passed++;
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_lock_frames();
    logic exp_fv;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(((k % 4) < 2) ? tn(P2) : on(P3));
      exp_fv = (k >= 9) && (((k - 9) % 4) == 0);
      total++;
      if (fv_s !== exp_fv) $display("FAIL lock_fv step %0d: got %b want %b", k, fv_s, exp_fv);
      else passed++;
    end
    total++; if (bus_if.tens_out !== 4'd2) $display("FAIL lock_tens: got %h want 2", bus_if.tens_out); else passed++;
    total++; if (bus_if.ones_out !== 4'd3) $display("FAIL lock_ones: got %h want 3", bus_if.ones_out); else passed++;
    total++; if (bus_if.value_out !== (BIN_EN ? 7'd23 : 7'd0)) $display("FAIL lock_value: got %0d want %0d", bus_if.value_out, BIN_EN ? 23 : 0); else passed++;
    total++; if (bus_if.err_seg !== 1'b0) $display("FAIL lock_err: got %b want 0", bus_if.err_seg); else passed++;
    total++; if (ll_s !== 1'b1) $display("FAIL lock_live: got %b want 1", ll_s); else passed++;
    $display("test_lock_frames: 20 steps of 2/3 stream");
  endtask

  task automatic test_short_phase();
    int base;
    do_reset();
    base = fv_cnt;
    pairs(P2, P3, 12);                 // steps 0-11, frames at 9 and 13
    step(tn(P2)); step(tn(P2));        // steps 12-13
    step(on(P3));                      // step 14: 1-cycle ones phase
    step(tn(P5)); step(tn(P5));        // steps 15-16
    total++; if (fv_cnt - base !== 2) $display("FAIL short_drop_count: got %0d want 2", fv_cnt - base); else passed++;
    total++; if (bus_if.tens_out !== 4'd2) $display("FAIL short_hold_tens: got %h want 2", bus_if.tens_out); else passed++;
    total++; if (bus_if.ones_out !== 4'd3) $display("FAIL short_hold_ones: got %h want 3", bus_if.ones_out); else passed++;
    step(on(P8)); step(on(P8));        // steps 17-18
    step(tn(P5)); step(tn(P5));        // steps 19-20, frame at 20
    total++; if (fv_cnt - base !== 3) $display("FAIL short_next_count: got %0d want 3", fv_cnt - base); else passed++;
    total++; if (bus_if.tens_out !== 4'd5) $display("FAIL short_next_tens: got %h want 5", bus_if.tens_out); else passed++;
    total++; if (bus_if.ones_out !== 4'd8) $display("FAIL short_next_ones: got %h want 8", bus_if.ones_out); else passed++;
    $display("test_short_phase: short ones phase dropped, 5/8 frame followed");
  endtask

  task automatic test_bad_pattern();
    int base;
    do_reset();
    base = fv_cnt;
    pairs(P2, P3, 8);                  // steps 0-7, frame at 9
    step(tn(PBAD)); step(tn(PBAD));    // steps 8-9, captured in step 10 cycle
    bus_if.err_clr = 1'b1;             // clear collides with the error set
    step(on(P3));                      // step 10
    bus_if.err_clr = 1'b0;
    step(on(P3));                      // step 11
    total++; if (bus_if.err_seg !== 1'b1) $display("FAIL bad_err_set: got %b want 1", bus_if.err_seg); else passed++;
    step(tn(P2)); step(tn(P2));        // steps 12-13
    total++; if (fv_cnt - base !== 1) $display("FAIL bad_no_frame: got %0d want 1", fv_cnt - base); else passed++;
    total++; if (bus_if.err_seg !== 1'b1) $display("FAIL bad_err_sticky: got %b want 1", bus_if.err_seg); else passed++;
    total++; if (bus_if.tens_out !== 4'd2) $display("FAIL bad_hold_tens: got %h want 2", bus_if.tens_out); else passed++;
    bus_if.err_clr = 1'b1;
    step(on(P3));                      // step 14
    bus_if.err_clr = 1'b0;
    step(on(P3));                      // step 15, frame at 17
    step(tn(P9)); step(tn(P9));        // steps 16-17
    step(on(P1)); step(on(P1));        // steps 18-19, frame at 21
    step(tn(P9)); step(tn(P9));        // steps 20-21
    total++; if (bus_if.err_seg !== 1'b0) $display("FAIL bad_err_clr: got %b want 0", bus_if.err_seg); else passed++;
    total++; if (fv_cnt - base !== 3) $display("FAIL bad_resume_count: got %0d want 3", fv_cnt - base); else passed++;
    total++; if (bus_if.tens_out !== 4'd9) $display("FAIL bad_resume_tens: got %h want 9", bus_if.tens_out); else passed++;
    total++; if (bus_if.ones_out !== 4'd1) $display("FAIL bad_resume_ones: got %h want 1", bus_if.ones_out); else passed++;
    $display("test_bad_pattern: illegal tens flagged, cleared, 9/1 frame followed");
  endtask

  task automatic test_blank_tens();
    int base;
    do_reset();
    base = fv_cnt;
    pairs(PBL, P7, 10);                // frame at 9
    total++; if (fv_cnt - base !== 1) $display("FAIL blank_count: got %0d want 1", fv_cnt - base); else passed++;
    total++; if (bus_if.tens_out !== 4'hF) $display("FAIL blank_tens: got %h want f", bus_if.tens_out); else passed++;
    total++; if (bus_if.ones_out !== 4'd7) $display("FAIL blank_ones: got %h want 7", bus_if.ones_out); else passed++;
    total++; if (bus_if.value_out !== (BIN_EN ? 7'h7F : 7'h00)) $display("FAIL blank_value: got %h want %h", bus_if.value_out, BIN_EN ? 7'h7F : 7'h00); else passed++;
    total++; if (bus_if.err_seg !== 1'b0) $display("FAIL blank_err: got %b want 0", bus_if.err_seg); else passed++;
    $display("test_blank_tens: blank tens with ones 7");
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    base = fv_cnt;
    pairs(P2, P3, 10);                 // last toggle enters at step 8
    for (int k = 10; k <= 80; k++) begin
      step(tn(P2));
      if (k == 12) begin
        total++; if (ll_s !== 1'b1) $display("FAIL to_live_early: got %b want 1", ll_s); else passed++;
      end
      if (k == 73) begin
        total++; if (ll_s !== 1'b1) $display("FAIL to_live_last: got %b want 1", ll_s); else passed++;
      end
      if (k == 74) begin
        total++; if (ll_s !== 1'b0) $display("FAIL to_live_drop: got %b want 0", ll_s); else passed++;
      end
    end
    total++; if (fv_cnt - base !== 1) $display("FAIL to_hold_count: got %0d want 1", fv_cnt - base); else passed++;
    total++; if (bus_if.tens_out !== 4'd2 || bus_if.ones_out !== 4'd3) $display("FAIL to_hold_out: got %h%h want 23", bus_if.tens_out, bus_if.ones_out); else passed++;
    step(on(P4)); step(on(P4));        // steps 81-82: ones first after stall
    step(tn(P6)); step(tn(P6));        // steps 83-84
    total++; if (fv_cnt - base !== 1) $display("FAIL to_relock_nofr: got %0d want 1", fv_cnt - base); else passed++;
    total++; if (ll_s !== 1'b1) $display("FAIL to_relock_live: got %b want 1", ll_s); else passed++;
    step(on(P4)); step(on(P4));        // steps 85-86, frame at 88
    step(tn(P6)); step(tn(P6));        // steps 87-88
    total++; if (fv_cnt - base !== 2) $display("FAIL to_relock_count: got %0d want 2", fv_cnt - base); else passed++;
    total++; if (bus_if.tens_out !== 4'd6 || bus_if.ones_out !== 4'd4) $display("FAIL to_relock_out: got %h%h want 64", bus_if.tens_out, bus_if.ones_out); else passed++;
    $display("test_timeout: link dropped after stall and re-locked");
  endtask

  task automatic test_reset_mid_phase();
    int base;
    do_reset();
    pairs(P2, P3, 8);                  // frame at 9
    step(tn(P5)); step(tn(P5));        // steps 8-9, tens 5 armed
    bus_if.disp_in = on(P8);           // step 10, reset lands mid-phase
    #3;
    reset = 1'b1;
    #1;
    total++; if (bus_if.tens_out !== 4'hF || bus_if.ones_out !== 4'hF) $display("FAIL rst_mid_out: got %h%h want ff", bus_if.tens_out, bus_if.ones_out); else passed++;
    total++; if (bus_if.value_out !== 7'h00) $display("FAIL rst_mid_value: got %h want 00", bus_if.value_out); else passed++;
    total++; if (bus_if.link_live !== 1'b0) $display("FAIL rst_mid_live: got %b want 0", bus_if.link_live); else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = fv_cnt;
    step(on(P8)); step(on(P8));        // steps 0-1: remainder of the ones phase
    step(tn(P1)); step(tn(P1));        // steps 2-3
    step(on(P7)); step(on(P7));        // steps 4-5, frame at 7
    total++; if (fv_cnt - base !== 0) $display("FAIL rst_mid_partial: got %0d want 0", fv_cnt - base); else passed++;
    total++; if (bus_if.tens_out !== 4'hF) $display("FAIL rst_mid_blank: got %h want f", bus_if.tens_out); else passed++;
    step(tn(P1)); step(tn(P1));        // steps 6-7
    total++; if (fv_cnt - base !== 1) $display("FAIL rst_mid_frame: got %0d want 1", fv_cnt - base); else passed++;
    total++; if (bus_if.tens_out !== 4'd1 || bus_if.ones_out !== 4'd7) $display("FAIL rst_mid_out2: got %h%h want 17", bus_if.tens_out, bus_if.ones_out); else passed++;
    $display("test_reset_mid_phase: reset during ones phase, 1/7 frame after release");
  endtask

  initial begin
    passed = 0;
    total  = 0;
    fv_cnt = 0;
    fv_s   = 1'b0;
    ll_s   = 1'b0;
    reset  = 1'b1;
    bus_if.disp_in = 8'h00;
    bus_if.err_clr = 1'b0;
    test_reset();
    test_lock_frames();
    test_short_phase();
    test_bad_pattern();
    test_blank_tens();
    test_timeout();
    test_reset_mid_phase();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
